pmem_burst_ctrl: RTL and testbench
==================================

# pmem_burst_ctrl

Physical-memory-side responder for the 256-bit line interface driven by the eviction write buffer, whose outputs are `pmem_read`, `pmem_write`, `pmem_address` and `pmem_wdata`. It accepts one line read or line write at a time and serializes it into a fixed-length burst on a narrow `bmem_*` bus. On a read it reassembles the returned beats into a 256-bit line. It completes every transaction with a one-cycle `pmem_resp`.

## Interface
- `BEAT_W`, default 64: burst beat width in bits. Legal values are 32, 64 and 128. `NBEATS` = 256/`BEAT_W`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pmem_read` input 1: line read request, held until `pmem_resp`.
- `pmem_write` input 1: line write request, held until `pmem_resp`.
- `pmem_address` input 32: byte address of the line; bits [4:0] are ignored.
- `pmem_wdata` input 256: line to be written.
- `pmem_resp` output 1: one-cycle transaction completion pulse.
- `pmem_rdata` output 256: assembled read line.
- `bmem_read` output 1: burst read in progress.
- `bmem_write` output 1: burst write in progress.
- `bmem_address` output 32: `{pmem_address[31:5], 5'b0}`, held for the whole burst.
- `bmem_wdata` output `BEAT_W`: current write beat.
- `bmem_rdata` input `BEAT_W`: read beat, valid when `bmem_resp` is high.
- `bmem_resp` input 1: one beat accepted (write) or delivered (read) this cycle.

## Operation
- **States:** IDLE, RD, WR, DONE.
  - Beat counter `cnt` is log2(`NBEATS`) bits wide.
  - Latched registers: `addr_q` (32 bits, low 5 bits zero), `line_q` (256 bits).
- **IDLE**
  - On `pmem_read`: latch the aligned address, set `cnt`=0, go to RD.
  - Otherwise, on `pmem_write`: latch the aligned address and `pmem_wdata` into `line_q`, set `cnt`=0, go to WR.
  - If both requests are high, the read wins. The write stays pending and is taken in a later IDLE cycle.
- **RD**
  - `bmem_read`=1.
  - On each cycle with `bmem_resp`=1: `line_q[cnt*BEAT_W +: BEAT_W]` ← `bmem_rdata`, then `cnt`++.
  - On the beat where `cnt`=`NBEATS`-1: go to DONE.
- **WR**
  - `bmem_write`=1 and `bmem_wdata` = `line_q[cnt*BEAT_W +: BEAT_W]`.
  - On each cycle with `bmem_resp`=1: `cnt`++.
  - On the last beat: go to DONE.
- **Beat order:** beat 0 is bits [`BEAT_W`-1:0], in ascending order. `bmem_resp` may have gap cycles; `cnt` advances only on `bmem_resp`.
- **DONE**
  - `pmem_resp`=1 for exactly one cycle, then go to IDLE.
  - For reads, `pmem_rdata` = `line_q` and holds that value until the next read's DONE.
  - Requests are ignored while in DONE.
- **`bmem_resp` outside RD/WR:** ignored.
- **`bmem_address`:** driven from `addr_q` in RD/WR and driven to 0 in IDLE/DONE.
- **Output decode:** `bmem_read`, `bmem_write` and `pmem_resp` are decoded from state only. They have no combinational path from `pmem_*` inputs.

## Timing
- **Reset values:** state=IDLE, `cnt`=0, `addr_q`=0, `line_q`=0. Therefore `pmem_resp`=0, `pmem_rdata`=0, `bmem_read`=0, `bmem_write`=0, `bmem_address`=0, `bmem_wdata`=0.
- **Reset mid-burst:** all outputs drop to their reset values asynchronously. The partial burst is abandoned and no `pmem_resp` is issued.
- **Latency:** request sampled in IDLE at edge 0 → RD/WR from cycle 1. With `bmem_resp` high every cycle, the beats complete at cycles 1..`NBEATS` and `pmem_resp` is high in cycle `NBEATS`+1. With `BEAT_W`=64 the request-to-resp time is 5 cycles.
- **Handshake:** the requester holds `pmem_read`/`pmem_write`, `pmem_address` and `pmem_wdata` stable until it samples `pmem_resp`=1. It deasserts the request in the following cycle.
  - The controller returns to IDLE in that same following cycle and may accept a new request there.
  - Minimum spacing between `pmem_resp` pulses is `NBEATS`+2 cycles.
- **Input sampling:** `pmem_wdata` and `pmem_address` are sampled only on the IDLE→RD/WR edge. Later changes have no effect.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → every output is 0 immediately and stays 0 with both requests low.
- **Line read:** read of 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with no gaps → `bmem_address`=0x0000_1220 for 4 cycles, `pmem_resp` in cycle 5, `pmem_rdata`={0x44..,0x33..,0x22..,0x11..}.
- **Line write with gaps:** write of 0x8000_0040, `wdata`=256'h0123…(four distinct 64-bit words), `bmem_resp` pattern 1,0,0,1,1,0,1 → beats appear in order 0..3, each held until accepted, `pmem_resp` one cycle after the fourth accept.
- **Simultaneous requests:** `pmem_read` and `pmem_write` high together → read burst first, `pmem_resp`, then the pending write is taken from IDLE and completes with a second `pmem_resp`.
- **Back-to-back:** read, write, read with the requester dropping each request the cycle after resp → exactly three resp pulses, each 6 cycles apart. `pmem_rdata` is unchanged through the write.
- **Reset mid-write:** `rst` pulsed after beat 2 → no `pmem_resp`, IDLE on release. A new read then completes normally in 5 cycles.

Source files
------------

// File: rtl/pmem_burst_ctrl.sv
// Line-to-burst bridge: serializes one 256-bit line read or write into NBEATS
// beats on the narrow bmem bus and reassembles read beats into a line.
module pmem_burst_ctrl #(
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [255:0]      pmem_wdata,
  output logic              pmem_resp,
  output logic [255:0]      pmem_rdata,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [31:0]       bmem_address,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp
);
  localparam int NBEATS = 256 / BEAT_W;
  localparam int CW     = $clog2(NBEATS);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [31:0]     addr_q;
  logic [255:0]    line_q, line_nxt, rdata_q;
  logic            last;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^pmem_address[4:0];
  assign last            = (cnt == CW'(NBEATS - 1));
  assign pmem_rdata      = rdata_q;

  always_comb begin
    line_nxt = line_q;
    line_nxt[int'(cnt) * BEAT_W +: BEAT_W] = bmem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs depend on state only, never on the pmem request inputs.
  always_comb begin
    state_nxt    = state;
    pmem_resp    = 1'b0;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_address = '0;
    bmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (pmem_read)       state_nxt = RD;
        else if (pmem_write) state_nxt = WR;
      end
      RD: begin
        bmem_read    = 1'b1;
        bmem_address = addr_q;
        if (bmem_resp && last) state_nxt = DONE;
      end
      WR: begin
        bmem_write   = 1'b1;
        bmem_address = addr_q;
        bmem_wdata   = line_q[int'(cnt) * BEAT_W +: BEAT_W];
        if (bmem_resp && last) state_nxt = DONE;
      end
      DONE: begin
        pmem_resp = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rdata_q is separate from line_q so a later write does not disturb the last read line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pmem_read) begin
            addr_q <= {pmem_address[31:5], 5'b0};
            cnt    <= '0;
          end else if (pmem_write) begin
            addr_q <= {pmem_address[31:5], 5'b0};
            line_q <= pmem_wdata;
            cnt    <= '0;
          end
        end
        RD: begin
          if (bmem_resp) begin
            line_q <= line_nxt;
            cnt    <= cnt + 1'b1;
            if (last) rdata_q <= line_nxt;
          end
        end
        WR: begin
          if (bmem_resp) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_ctrl.sv
// Scoreboard bench for pmem_burst_ctrl: stimulus queues expected responses,
// a bmem responder serves beats and a monitor checks every pmem_resp.
module tb_pmem_burst_ctrl;
  localparam int BW = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pmem_read = 1'b0, pmem_write = 1'b0;
  logic [31:0]    pmem_address = '0;
  logic [255:0]   pmem_wdata = '0;
  logic           pmem_resp;
  logic [255:0]   pmem_rdata;
  logic           bmem_read, bmem_write;
  logic [31:0]    bmem_address;
  logic [BW-1:0]  bmem_wdata;
  logic [BW-1:0]  bmem_rdata = '0;
  logic           bmem_resp = 1'b0;

  pmem_burst_ctrl #(.BEAT_W(BW)) dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_address(bmem_address), .bmem_wdata(bmem_wdata),
    .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct {
    logic [255:0] rdata;
    int           cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [BW-1:0] rd_beats[$];
  logic [BW-1:0] wexp[$];
  bit            pat[$];
  bit            resp_bit;
  logic [31:0]   exp_addr = '0;
  int            wacc = 0;

  localparam logic [255:0] L1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
  localparam logic [255:0] W1 = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
  localparam logic [255:0] L2 = 256'hdddddddddddddddd_cccccccccccccccc_bbbbbbbbbbbbbbbb_aaaaaaaaaaaaaaaa;
  localparam logic [255:0] W2 = 256'h5555555555555555_6666666666666666_7777777777777777_8888888888888888;
  localparam logic [255:0] L3 = 256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101;
  localparam logic [255:0] L4 = 256'h0d0d0d0d0d0d0d0d_0c0c0c0c0c0c0c0c_0b0b0b0b0b0b0b0b_0a0a0a0a0a0a0a0a;
  localparam logic [255:0] L5 = 256'hfeedface00000004_feedface00000003_feedface00000002_feedface00000001;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".pmem_resp"},    256'(pmem_resp),    '0);
    chk({tag, ".pmem_rdata"},   pmem_rdata,         '0);
    chk({tag, ".bmem_read"},    256'(bmem_read),    '0);
    chk({tag, ".bmem_write"},   256'(bmem_write),   '0);
    chk({tag, ".bmem_address"}, 256'(bmem_address), '0);
    chk({tag, ".bmem_wdata"},   256'(bmem_wdata),   '0);
  endtask

  task automatic push_rd4(input logic [BW-1:0] b0, b1, b2, b3);
    rd_beats.push_back(b0); rd_beats.push_back(b1);
    rd_beats.push_back(b2); rd_beats.push_back(b3);
  endtask

  task automatic push_w4(input logic [BW-1:0] b0, b1, b2, b3);
    wexp.push_back(b0); wexp.push_back(b1);
    wexp.push_back(b2); wexp.push_back(b3);
  endtask

  // resp expected 5 cycles after issue plus one per gap cycle
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [255:0] wd, input logic [31:0] exp_a,
                       input int gaps, input logic [255:0] exp_rd);
    exp_t e;
    e.rdata = exp_rd;
    e.cyc   = cyc + 5 + gaps;
    sb.push_back(e);
    exp_addr     = exp_a;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = wd;
  endtask

  task automatic wait_resp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_resp && n < 40);
    if (!pmem_resp) begin
      checks++; failures++;
      $display("FAIL wait_resp: no pmem_resp within %0d cycles", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic drop();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  // bmem side: answers each active cycle, honoring an optional gap pattern
  always begin
    @(posedge clk); #2;
    if (bmem_read || bmem_write) begin
      resp_bit = (pat.size() > 0) ? pat.pop_front() : 1'b1;
      chk("bmem_address", 256'(bmem_address), 256'(exp_addr));
      bmem_resp = resp_bit;
      if (bmem_read)
        bmem_rdata = (resp_bit && rd_beats.size() > 0) ? rd_beats.pop_front() : {$urandom, $urandom};
      if (bmem_write) begin
        if (wexp.size() > 0) begin
          chk("bmem_wdata", 256'(bmem_wdata), 256'(wexp[0]));
          if (resp_bit) begin
            void'(wexp.pop_front());
            wacc++;
          end
        end else begin
          checks++; failures++;
          $display("FAIL bmem_wdata: unexpected write beat %h", bmem_wdata);
        end
      end
    end else begin
      bmem_resp  = 1'b0;
      bmem_rdata = {$urandom, $urandom};
    end
  end

  always @(negedge clk) begin
    if (!rst && pmem_resp) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL pmem_resp: unexpected pulse at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_cycle", 256'(cyc), 256'(mon_e.cyc));
        chk("pmem_rdata", pmem_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0;
    #2;
    chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("post_reset");

    // line read, no gaps
    push_rd4(64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444);
    issue(1'b1, 1'b0, 32'h0000_1234, '0, 32'h0000_1220, 0, L1);
    wait_resp(); drop();
    repeat (2) @(posedge clk); #1;

    // line write with bmem_resp gaps; pmem_rdata keeps the previous read line
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    push_w4(64'h8796a5b4c3d2e1f0, 64'h0f1e2d3c4b5a6978, 64'hfedcba9876543210, 64'h0123456789abcdef);
    issue(1'b0, 1'b1, 32'h8000_0040, W1, 32'h8000_0040, 3, L1);
    wait_resp(); drop();
    repeat (2) @(posedge clk); #1;

    // simultaneous read and write: read first, write taken afterwards
    push_rd4(64'haaaaaaaaaaaaaaaa, 64'hbbbbbbbbbbbbbbbb, 64'hcccccccccccccccc, 64'hdddddddddddddddd);
    push_w4(64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555);
    issue(1'b1, 1'b1, 32'h0000_2010, W2, 32'h0000_2000, 0, L2);
    wait_resp();
    issue(1'b0, 1'b1, 32'h0000_2010, W2, 32'h0000_2000, 0, L2);
    wait_resp(); drop();
    repeat (2) @(posedge clk); #1;

    // back-to-back read, write, read: resp pulses 6 cycles apart
    push_rd4(64'h0101010101010101, 64'h0202020202020202, 64'h0303030303030303, 64'h0404040404040404);
    issue(1'b1, 1'b0, 32'hdead_beef, '0, 32'hdead_bee0, 0, L3);
    wait_resp();
    push_w4(64'h8796a5b4c3d2e1f0, 64'h0f1e2d3c4b5a6978, 64'hfedcba9876543210, 64'h0123456789abcdef);
    issue(1'b0, 1'b1, 32'h0000_005f, W1, 32'h0000_0040, 0, L3);
    wait_resp();
    push_rd4(64'h0a0a0a0a0a0a0a0a, 64'h0b0b0b0b0b0b0b0b, 64'h0c0c0c0c0c0c0c0c, 64'h0d0d0d0d0d0d0d0d);
    issue(1'b1, 1'b0, 32'h1234_5678, '0, 32'h1234_5660, 0, L4);
    wait_resp(); drop();
    repeat (2) @(posedge clk); #1;

    // reset in the middle of a write burst: no resp, outputs clear at once
    push_w4(64'h8796a5b4c3d2e1f0, 64'h0f1e2d3c4b5a6978, 64'hfedcba9876543210, 64'h0123456789abcdef);
    exp_addr     = 32'h0000_0300;
    pmem_address = 32'h0000_0300;
    pmem_wdata   = W1;
    pmem_write   = 1'b1;
    w0 = wacc;
    n  = 0;
    while (wacc < w0 + 2 && n < 20) begin
      @(posedge clk); #3;
      n++;
    end
    if (wacc < w0 + 2) begin
      checks++; failures++;
      $display("FAIL midwrite: only %0d beats accepted", wacc - w0);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1 chk_idle_outputs("async_reset");
    drop();
    wexp.delete(); pat.delete(); rd_beats.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("after_reset");

    push_rd4(64'hfeedface00000001, 64'hfeedface00000002, 64'hfeedface00000003, 64'hfeedface00000004);
    issue(1'b1, 1'b0, 32'h0000_0100, '0, 32'h0000_0100, 0, L5);
    wait_resp(); drop();

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", 256'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
